hilbert_transformer_mc: RTL and testbench

Multi-channel, time-multiplexed Hilbert transformer for the lock-in / phase-demodulation path. On each sample tick it captures NUM_CHANNELS input samples and produces a quadrature pair per channel. sin_o is the Hilbert FIR output; cos_o is the matching delay FIR output. One shared dual MAC iterates over taps and channels, replacing one full filter instance per channel.

---
 rtl/hilbert_pkg.sv | 31 +++
 rtl/hilbert_transformer_mc_mac.sv | 41 ++++
 rtl/hilbert_transformer_mc.sv | 150 +++++++++++++++
 tb/tb_hilbert_transformer_mc.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hilbert_pkg.sv
// Shared types and arithmetic helpers for the multi-channel Hilbert transformer.
// HILBERT_SATURATE_EN selects saturation instead of wrap-around when reducing results.
package hilbert_pkg;

    typedef enum logic [1:0] {IDLE, MAC, STORE, DONE} state_t;

    // Working width for result reduction; comfortably wider than any accumulator in use.
    localparam int MAX_W = 128;

    function automatic int acc_width(input int num_bits, input int coeff_length);
        return 2 * num_bits + $clog2(coeff_length);
    endfunction

    // Reduces an already-shifted accumulator to num_bits; caller keeps the low num_bits bits.
    function automatic logic signed [MAX_W-1:0] reduce_result(input logic signed [MAX_W-1:0] value,
                                                              input int num_bits);
`ifdef HILBERT_SATURATE_EN
        logic signed [MAX_W-1:0] hi;
        logic signed [MAX_W-1:0] lo;
        hi = 1;
        hi = (hi <<< (num_bits - 1)) - 1;
        lo = -hi - 1;
        if (value > hi) return hi;
        if (value < lo) return lo;
        return value;
`else
        return (value <<< (MAX_W - num_bits)) >>> (MAX_W - num_bits);
`endif
    endfunction

endpackage

// File: rtl/hilbert_transformer_mc_mac.sv
// Two signed multiply-accumulators sharing one sample operand, with synchronous clear and enable.
module hilbert_dual_mac #(
    parameter int NUM_BITS = 24,
    parameter int ACC_W    = 52
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clr,
    input  logic                       en,
    input  logic signed [NUM_BITS-1:0] coef_a,
    input  logic signed [NUM_BITS-1:0] coef_b,
    input  logic signed [NUM_BITS-1:0] sample,
    output logic signed [ACC_W-1:0]    acc_a,
    output logic signed [ACC_W-1:0]    acc_b
);

    logic signed [2*NUM_BITS-1:0] prod_a;
    logic signed [2*NUM_BITS-1:0] prod_b;
    logic signed [ACC_W-1:0]      ext_a;
    logic signed [ACC_W-1:0]      ext_b;

    assign prod_a = coef_a * sample;
    assign prod_b = coef_b * sample;
    assign ext_a  = {{(ACC_W-2*NUM_BITS){prod_a[2*NUM_BITS-1]}}, prod_a};
    assign ext_b  = {{(ACC_W-2*NUM_BITS){prod_b[2*NUM_BITS-1]}}, prod_b};

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_a <= '0;
            acc_b <= '0;
        end else if (clr) begin
            acc_a <= '0;
            acc_b <= '0;
        end else if (en) begin
            acc_a <= acc_a + ext_a;
            acc_b <= acc_b + ext_b;
        end
    end

endmodule

// File: rtl/hilbert_transformer_mc.sv
// Time-multiplexed Hilbert/delay FIR pair over NUM_CHANNELS inputs using one shared dual MAC.
// Define HILBERT_SATURATE_EN to saturate results; otherwise they wrap to NUM_BITS.
module hilbert_transformer_mc
    import hilbert_pkg::*;
#(
    parameter int NUM_BITS     = 24,
    parameter int COEFF_LENGTH = 13,
    parameter int NUM_CHANNELS = 2
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic                       tick_i,
    input  logic signed [NUM_BITS-1:0] signal_i     [NUM_CHANNELS],
    input  logic signed [NUM_BITS-1:0] ha_coeffs    [COEFF_LENGTH],
    input  logic signed [NUM_BITS-1:0] delay_coeffs [COEFF_LENGTH],
    output logic signed [NUM_BITS-1:0] sin_o        [NUM_CHANNELS],
    output logic signed [NUM_BITS-1:0] cos_o        [NUM_CHANNELS],
    output logic                       done_o,
    output logic                       busy_o,
    output logic                       overrun_o
);

    localparam int ACC_W = acc_width(NUM_BITS, COEFF_LENGTH);
    localparam int CH_W  = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
    localparam int K_W   = $clog2(COEFF_LENGTH);
    localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CHANNELS - 1);
    localparam logic [K_W-1:0]  LAST_K  = K_W'(COEFF_LENGTH - 1);

    state_t                      state;
    state_t                      state_next;
    logic [CH_W-1:0]             ch;
    logic [K_W-1:0]              k;
    logic                        accept;
    logic                        mac_clr;
    logic                        mac_en;
    logic signed [NUM_BITS-1:0]  dline [NUM_CHANNELS][COEFF_LENGTH];
    logic signed [ACC_W-1:0]     acc_ha;
    logic signed [ACC_W-1:0]     acc_d;
    logic signed [ACC_W-1:0]     sh_ha;
    logic signed [ACC_W-1:0]     sh_d;
    logic signed [NUM_BITS-1:0]  res_ha;
    logic signed [NUM_BITS-1:0]  res_d;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) state <= IDLE;
        else         state <= state_next;
    end

    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        mac_clr    = 1'b0;
        mac_en     = 1'b0;
        done_o     = 1'b0;
        busy_o     = 1'b1;
        case (state)
            IDLE: begin
                busy_o = 1'b0;
                if (tick_i) begin
                    accept     = 1'b1;
                    mac_clr    = 1'b1;
                    state_next = MAC;
                end
            end
            MAC: begin
                mac_en = 1'b1;
                if (k == LAST_K) state_next = STORE;
            end
            STORE: begin
                mac_clr    = 1'b1;
                state_next = (ch == LAST_CH) ? DONE : MAC;
            end
            DONE: begin
                done_o     = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            ch <= '0;
            k  <= '0;
        end else if (accept) begin
            ch <= '0;
            k  <= '0;
        end else if (state == MAC) begin
            k <= (k == LAST_K) ? '0 : k + K_W'(1);
        end else if (state == STORE) begin
            k <= '0;
            if (ch != LAST_CH) ch <= ch + CH_W'(1);
        end
    end

    // NOTE: the delay line is reset deliberately so a computation after reset starts from silence.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            for (int c = 0; c < NUM_CHANNELS; c++)
                for (int t = 0; t < COEFF_LENGTH; t++)
                    dline[c][t] <= '0;
        end else if (accept) begin
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                dline[c][0] <= signal_i[c];
                for (int t = 1; t < COEFF_LENGTH; t++)
                    dline[c][t] <= dline[c][t-1];
            end
        end
    end

    hilbert_dual_mac #(
        .NUM_BITS (NUM_BITS),
        .ACC_W    (ACC_W)
    ) u_mac (
        .clk    (clk_i),
        .rst    (reset_i),
        .clr    (mac_clr),
        .en     (mac_en),
        .coef_a (ha_coeffs[k]),
        .coef_b (delay_coeffs[k]),
        .sample (dline[ch][k]),
        .acc_a  (acc_ha),
        .acc_b  (acc_d)
    );

    // Q1.(NUM_BITS-1) coefficients: drop the fractional bits, rounding toward minus infinity.
    assign sh_ha  = acc_ha >>> (NUM_BITS - 1);
    assign sh_d   = acc_d  >>> (NUM_BITS - 1);
    assign res_ha = NUM_BITS'(reduce_result({{(MAX_W-ACC_W){sh_ha[ACC_W-1]}}, sh_ha}, NUM_BITS));
    assign res_d  = NUM_BITS'(reduce_result({{(MAX_W-ACC_W){sh_d[ACC_W-1]}},  sh_d},  NUM_BITS));

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                sin_o[c] <= '0;
                cos_o[c] <= '0;
            end
        end else if (state == STORE) begin
            sin_o[ch] <= res_ha;
            cos_o[ch] <= res_d;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i)                        overrun_o <= 1'b0;
        else if (tick_i && state != IDLE)   overrun_o <= 1'b1;
    end

endmodule

// File: tb/tb_hilbert_transformer_mc.sv
// Self-checking bench for hilbert_transformer_mc: vector table, directed corner sequences and
// randomized ticks against a sum-of-products reference model (honours HILBERT_SATURATE_EN).
module tb_hilbert_transformer_mc;

    localparam int NB = 24;
    localparam int CL = 13;
    localparam int NC = 2;
    localparam longint MAXV = (longint'(1) <<< (NB - 1)) - 1;
    localparam longint MINV = -(longint'(1) <<< (NB - 1));
    localparam longint FULL = longint'(1) <<< NB;

    logic clk = 1'b0;
    logic reset_i;
    logic tick;
    logic signed [NB-1:0] signal [NC];
    logic signed [NB-1:0] ha [CL];
    logic signed [NB-1:0] dl [CL];
    logic signed [NB-1:0] sin_o [NC];
    logic signed [NB-1:0] cos_o [NC];
    logic done_o, busy_o, overrun_o;

    int vectors = 0;
    int miscompares = 0;
    longint hist [NC][$];

    typedef struct {
        longint s0, s1;
        longint sin0, sin1, cos0, cos1;
    } vec_t;
    vec_t tbl [CL];

    always #5 clk = ~clk;

    hilbert_transformer_mc #(
        .NUM_BITS(NB), .COEFF_LENGTH(CL), .NUM_CHANNELS(NC)
    ) dut (
        .clk_i(clk), .reset_i(reset_i), .tick_i(tick), .signal_i(signal),
        .ha_coeffs(ha), .delay_coeffs(dl), .sin_o(sin_o), .cos_o(cos_o),
        .done_o(done_o), .busy_o(busy_o), .overrun_o(overrun_o)
    );

    task automatic check(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: y[n] = sum_k c[k] * x[n-k], floor-divided by 2^(NB-1), then reduced to NB bits.
    function automatic longint reduce_ref(input longint acc);
        longint s;
        s = acc >>> (NB - 1);
`ifdef HILBERT_SATURATE_EN
        if (s > MAXV) s = MAXV;
        if (s < MINV) s = MINV;
`else
        s = s & (FULL - 1);
        if (s > MAXV) s = s - FULL;
`endif
        return s;
    endfunction

    function automatic longint ref_out(input int c, input bit hil);
        longint acc = 0;
        for (int t = 0; t < hist[c].size(); t++)
            acc += (hil ? longint'(ha[t]) : longint'(dl[t])) * hist[c][t];
        return reduce_ref(acc);
    endfunction

    task automatic model_shift(input longint s0, input longint s1);
        hist[0].push_front(s0);
        hist[1].push_front(s1);
        for (int c = 0; c < NC; c++)
            if (hist[c].size() > CL) void'(hist[c].pop_back());
    endtask

    task automatic check_model(input string tag);
        for (int c = 0; c < NC; c++) begin
            check($sformatf("%s sin[%0d]", tag, c), sin_o[c], ref_out(c, 1'b1));
            check($sformatf("%s cos[%0d]", tag, c), cos_o[c], ref_out(c, 1'b0));
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_i = 1'b1;
        tick = 1'b0;
        for (int c = 0; c < NC; c++) hist[c].delete();
        repeat (2) @(negedge clk);
        reset_i = 1'b0;
    endtask

    task automatic default_coeffs();
        for (int t = 0; t < CL; t++) begin
            ha[t] = '0;
            dl[t] = '0;
        end
        dl[CL/2] = NB'(MAXV);
    endtask

    // Applies one accepted tick and waits (bounded) for done_o; returns at the done cycle.
    task automatic run_tick(input longint s0, input longint s1, input string tag);
        int lat;
        @(negedge clk);
        signal[0] = NB'(s0);
        signal[1] = NB'(s1);
        tick = 1'b1;
        model_shift(s0, s1);
        lat = -1;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            tick = 1'b0;
            if (done_o) begin
                lat = i;
                break;
            end
        end
        check({tag, " latency"}, lat, 2 * (CL + 1) + 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int dcnt, bcnt, dpos;
        logic signed [NB-1:0] r0, r1;

        reset_i = 1'b1;
        tick = 1'b0;
        signal[0] = '0;
        signal[1] = '0;
        default_coeffs();
        for (int i = 0; i < CL; i++) begin
            tbl[i].s0   = (i == 0) ? 1000 : 0;
            tbl[i].s1   = 0;
            tbl[i].sin0 = 0;
            tbl[i].sin1 = 0;
            tbl[i].cos0 = (i == CL/2) ? 999 : 0;
            tbl[i].cos1 = 0;
        end
        repeat (3) @(negedge clk);
        reset_i = 1'b0;

        // Idle after reset.
        dcnt = 0;
        bcnt = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (done_o) dcnt++;
            if (busy_o) bcnt++;
        end
        check("idle done pulses", dcnt, 0);
        check("idle busy cycles", bcnt, 0);
        check("idle overrun", overrun_o, 0);
        for (int c = 0; c < NC; c++) begin
            check($sformatf("idle sin[%0d]", c), sin_o[c], 0);
            check($sformatf("idle cos[%0d]", c), cos_o[c], 0);
        end

        // Impulse through the delay path, expectations from the table.
        foreach (tbl[i]) begin
            run_tick(tbl[i].s0, tbl[i].s1, $sformatf("impulse%0d", i));
            check($sformatf("impulse%0d sin[0]", i), sin_o[0], tbl[i].sin0);
            check($sformatf("impulse%0d sin[1]", i), sin_o[1], tbl[i].sin1);
            check($sformatf("impulse%0d cos[0]", i), cos_o[0], tbl[i].cos0);
            check($sformatf("impulse%0d cos[1]", i), cos_o[1], tbl[i].cos1);
        end

        // Antisymmetric Hilbert taps with DC on ch1.
        ha = '{0, -28824, 0, -605240, 0, -4769003, 0, 4769003, 0, 605240, 0, 28824, 0};
        for (int i = 1; i <= CL; i++) begin
            run_tick(0, 1000, $sformatf("dc%0d", i));
            check_model($sformatf("dc%0d", i));
        end
        check("dc settled sin[1]", sin_o[1], 0);
        check("dc settled cos[1]", cos_o[1], 999);

        // Random taps and samples against the model.
        for (int t = 0; t < CL; t++) begin
            ha[t] = NB'($urandom);
            dl[t] = NB'($urandom);
        end
        for (int i = 0; i < 20; i++) begin
            r0 = NB'($urandom);
            r1 = NB'($urandom);
            run_tick(r0, r1, $sformatf("rand%0d", i));
            check_model($sformatf("rand%0d", i));
        end

        // Second tick 10 cycles into a computation is dropped.
        do_reset();
        @(negedge clk);
        signal[0] = NB'(111);
        signal[1] = NB'(-222);
        tick = 1'b1;
        model_shift(111, -222);
        dcnt = 0;
        dpos = -1;
        for (int i = 1; i <= 60; i++) begin
            @(negedge clk);
            tick = (i == 10);
            if (i == 10) begin
                signal[0] = NB'(777);
                signal[1] = NB'(888);
            end
            if (i == 9) check("overrun before", overrun_o, 0);
            if (done_o) begin
                dcnt++;
                if (dpos < 0) dpos = i;
            end
            if (i == dpos + 1) begin
                check("done one cycle", done_o, 0);
                check("idle after done", busy_o, 0);
            end
        end
        check("overrun done count", dcnt, 1);
        check("overrun done position", dpos, 29);
        check("overrun sticky", overrun_o, 1);
        check_model("overrun");
        run_tick(5, -6, "after overrun");
        check_model("after overrun");
        check("overrun still set", overrun_o, 1);

        // Tick coinciding with the DONE cycle is also dropped.
        do_reset();
        run_tick(300, 400, "done-tick first");
        check("no overrun yet", overrun_o, 0);
        signal[0] = NB'(999);
        signal[1] = NB'(999);
        tick = 1'b1;
        dcnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            tick = 1'b0;
            if (done_o) dcnt++;
        end
        check("done-tick extra dones", dcnt, 0);
        check("done-tick overrun", overrun_o, 1);
        run_tick(7, 8, "done-tick next");
        check_model("done-tick next");

        // Full-scale input on the odd Hilbert taps.
        do_reset();
        default_coeffs();
        for (int t = 1; t < CL; t += 2) ha[t] = NB'(MAXV);
        for (int i = 1; i <= CL; i++) begin
            run_tick(MAXV, MAXV, $sformatf("sat%0d", i));
            check_model($sformatf("sat%0d", i));
        end
`ifdef HILBERT_SATURATE_EN
        check("sat sin[0]", sin_o[0], MAXV);
`else
        check("wrap sin[0]", sin_o[0], -12);
`endif
        check("full-scale cos[0]", cos_o[0], 8388606);

        // Reset while channel 1 is accumulating.
        for (int t = 0; t < CL; t++) ha[t] = NB'($urandom);
        do_reset();
        @(negedge clk);
        signal[0] = NB'(123456);
        signal[1] = NB'(-654321);
        tick = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            tick = 1'b0;
        end
        check("mid busy", busy_o, 1);
        #2;
        reset_i = 1'b1;
        for (int c = 0; c < NC; c++) hist[c].delete();
        #1;
        check("mid reset busy", busy_o, 0);
        check("mid reset done", done_o, 0);
        for (int c = 0; c < NC; c++) begin
            check($sformatf("mid reset sin[%0d]", c), sin_o[c], 0);
            check($sformatf("mid reset cos[%0d]", c), cos_o[c], 0);
        end
        @(negedge clk);
        reset_i = 1'b0;
        dcnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done_o) dcnt++;
        end
        check("mid reset no done", dcnt, 0);
        run_tick(-4242, 31337, "post reset");
        check_model("post reset");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
